// File: rtl/startup_sequencer.sv
// Reset-and-start sequencer: merges reset causes into a stretched sys_rst, then
// emits a delayed start pulse, either one-shot with retrigger or periodic.
module startup_sequencer #(
  parameter int NUM_SRC     = 5,
  parameter int RST_HOLD    = 16,
  parameter int DELAY_W     = 29,
  parameter int START_DELAY = 536870910,
  parameter int PULSE_W     = 1,
  parameter int MODE        = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               eos,
  input  logic [NUM_SRC-1:0] rst_req,
  input  logic [NUM_SRC-1:0] rst_mask,
  input  logic               retrigger,
  output logic               sys_rst,
  output logic               start,
  output logic [1:0]         state,
  output logic [DELAY_W-1:0] delay_cnt
);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD);
  localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'(START_DELAY - 1);
  localparam logic [7:0]         PULSE_LAST = 8'(PULSE_W - 1);

  logic [NUM_SRC-1:0] w_req_active;
  logic               w_cause;

  state_t             r_state, w_state_next;
  logic               r_sys_rst, w_sys_rst_next;
  logic               r_start, w_start_next;
  logic [DELAY_W-1:0] r_delay_cnt, w_delay_cnt_next;
  logic [HOLD_W-1:0]  r_hold_cnt, w_hold_cnt_next;
  logic [HOLD_W-1:0]  w_hold_inc;
  logic [7:0]         r_pulse_cnt, w_pulse_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_req
      assign w_req_active[gi] = rst_req[gi] & ~rst_mask[gi];
    end
  endgenerate

  assign w_cause    = rst | ~eos | (|w_req_active);
  assign w_hold_inc = r_hold_cnt + 1'b1;

  always_comb begin
    w_state_next     = r_state;
    w_sys_rst_next   = r_sys_rst;
    w_start_next     = r_start;
    w_delay_cnt_next = r_delay_cnt;
    w_hold_cnt_next  = r_hold_cnt;
    w_pulse_cnt_next = r_pulse_cnt;
    if (w_cause) begin
      // Any cause overrides every state, including the last pulse cycle.
      w_state_next     = ST_HOLD;
      w_sys_rst_next   = 1'b1;
      w_start_next     = 1'b0;
      w_delay_cnt_next = '0;
      w_hold_cnt_next  = '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          w_hold_cnt_next = w_hold_inc;
          if (w_hold_inc == HOLD_LAST) begin
            w_state_next     = ST_DELAY;
            w_sys_rst_next   = 1'b0;
            w_delay_cnt_next = '0;
          end
        end
        ST_DELAY: begin
          // delay_cnt freezes at START_DELAY-1 so it never wraps.
          if (r_delay_cnt == DELAY_LAST) begin
            w_state_next     = ST_PULSE;
            w_start_next     = 1'b1;
            w_pulse_cnt_next = '0;
          end else begin
            w_delay_cnt_next = r_delay_cnt + 1'b1;
          end
        end
        ST_PULSE: begin
          if (r_pulse_cnt == PULSE_LAST) begin
            w_start_next = 1'b0;
            if (MODE == 1) begin
              w_state_next     = ST_DELAY;
              w_delay_cnt_next = '0;
            end else begin
              w_state_next = ST_DONE;
            end
          end else begin
            w_pulse_cnt_next = r_pulse_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if ((MODE == 0) && retrigger) begin
            w_state_next     = ST_DELAY;
            w_delay_cnt_next = '0;
          end
        end
        default: begin
          w_state_next = ST_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_HOLD;
      r_sys_rst   <= 1'b1;
      r_start     <= 1'b0;
      r_delay_cnt <= '0;
      r_hold_cnt  <= '0;
      r_pulse_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sys_rst   <= w_sys_rst_next;
      r_start     <= w_start_next;
      r_delay_cnt <= w_delay_cnt_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_pulse_cnt <= w_pulse_cnt_next;
    end
  end

  assign sys_rst   = r_sys_rst;
  assign start     = r_start;
  assign state     = r_state;
  assign delay_cnt = r_delay_cnt;

endmodule

// File: tb/tb_startup_sequencer.sv
// Bench for startup_sequencer: table vectors, directed corner sequences and a
// random run, with a one-shot and a periodic instance checked against a timeline model.
module tb_startup_sequencer;

  localparam int NS = 2;
  localparam int RH = 4;
  localparam int DW = 8;
  localparam int SD = 10;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          eos = 1'b1;
  logic          retrigger = 1'b0;
  logic [NS-1:0] rst_req = '0;
  logic [NS-1:0] rst_mask = '0;

  logic          sr0, st0, sr1, st1;
  logic [1:0]    s0, s1;
  logic [DW-1:0] d0, d1;

  int errors = 0;
  int checks = 0;

  // Timeline model: clean edges while in reset, then edges elapsed since the
  // delay phase began (t); all outputs follow from t by plain arithmetic.
  typedef struct {
    int clean;
    bit rel;
    int t;
  } mstate_t;

  mstate_t m0 = '{0, 1'b0, 0};
  mstate_t m1 = '{0, 1'b0, 0};
  logic    m_cause;

  typedef struct {
    logic       rst;
    logic       eos;
    logic [1:0] req;
    logic [1:0] mask;
    logic       retrig;
    logic       esr;
    logic       est;
    logic [1:0] es;
    logic [7:0] ed;
  } vec_t;

  vec_t vq[$];

  startup_sequencer #(.NUM_SRC(NS), .RST_HOLD(RH), .DELAY_W(DW), .START_DELAY(SD),
                      .PULSE_W(PW), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .eos(eos), .rst_req(rst_req), .rst_mask(rst_mask),
    .retrigger(retrigger), .sys_rst(sr0), .start(st0), .state(s0), .delay_cnt(d0));

  startup_sequencer #(.NUM_SRC(NS), .RST_HOLD(RH), .DELAY_W(DW), .START_DELAY(SD),
                      .PULSE_W(PW), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .eos(eos), .rst_req(rst_req), .rst_mask(rst_mask),
    .retrigger(retrigger), .sys_rst(sr1), .start(st1), .state(s1), .delay_cnt(d1));

  always #5 clk = ~clk;

  assign m_cause = rst | ~eos | (|(rst_req & ~rst_mask));

  function automatic mstate_t mnext(mstate_t s, logic cause, logic retrig, bit mode);
    mstate_t n = s;
    if (cause) begin
      n.rel = 1'b0; n.clean = 0; n.t = 0;
    end else if (!s.rel) begin
      n.clean = s.clean + 1;
      if (n.clean == RH) begin
        n.rel = 1'b1; n.t = 0;
      end
    end else if (s.t == SD + PW) begin
      if (retrig && !mode) n.t = 0;
    end else begin
      n.t = s.t + 1;
      if (mode && n.t == SD + PW) n.t = 0;
    end
    return n;
  endfunction

  function automatic logic [11:0] mout(mstate_t s);
    logic [1:0] st;
    logic [7:0] dc;
    logic       pulse;
    if (!s.rel) return {1'b1, 1'b0, 2'd0, 8'd0};
    st    = (s.t < SD) ? 2'd1 : ((s.t < SD + PW) ? 2'd2 : 2'd3);
    pulse = (st == 2'd2);
    dc    = (s.t < SD) ? 8'(s.t) : 8'(SD - 1);
    return {1'b0, pulse, st, dc};
  endfunction

  always @(posedge clk) begin
    m0 <= mnext(m0, m_cause, retrigger, 1'b0);
    m1 <= mnext(m1, m_cause, retrigger, 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    checks += 2;
    if ({sr0, st0, s0, d0} !== mout(m0)) begin
      errors++;
      $display("FAIL model_mode0 at %0t: got=%h want=%h", $time, {sr0, st0, s0, d0}, mout(m0));
    end
    if ({sr1, st1, s1, d1} !== mout(m1)) begin
      errors++;
      $display("FAIL model_mode1 at %0t: got=%h want=%h", $time, {sr1, st1, s1, d1}, mout(m1));
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect0(string name, logic esr, logic est, logic [1:0] es, logic [7:0] ed);
    checks++;
    if ({sr0, st0, s0, d0} !== {esr, est, es, ed}) begin
      errors++;
      $display("FAIL %s: got sys_rst=%b start=%b state=%0d delay_cnt=%0d, want %b %b %0d %0d",
               name, sr0, st0, s0, d0, esr, est, es, ed);
    end else begin
      $display("ok %s: sys_rst=%b start=%b state=%0d delay_cnt=%0d", name, sr0, st0, s0, d0);
    end
  endtask

  function automatic vec_t mkv(int r, int e, int rq, int mk, int rt,
                               int esr, int est, int es, int ed);
    vec_t v;
    v.rst = 1'(r); v.eos = 1'(e); v.req = 2'(rq); v.mask = 2'(mk); v.retrig = 1'(rt);
    v.esr = 1'(esr); v.est = 1'(est); v.es = 2'(es); v.ed = 8'(ed);
    return v;
  endfunction

  initial begin
    // Power-up reset and release: sys_rst stretch, delay ramp, pulse, DONE.
    for (int i = 0; i < 3; i++) vq.push_back(mkv(1, 1, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < RH - 1; i++) vq.push_back(mkv(0, 1, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < SD; i++) vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 1, i));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 1, 2, SD - 1));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 1, 2, SD - 1));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 3, SD - 1));
    vq.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 3, SD - 1));

    foreach (vq[i]) begin
      rst = vq[i].rst; eos = vq[i].eos; rst_req = vq[i].req;
      rst_mask = vq[i].mask; retrigger = vq[i].retrig;
      tick();
      expect0($sformatf("vec%0d", i), vq[i].esr, vq[i].est, vq[i].es, vq[i].ed);
    end

    // Retrigger from DONE works, retrigger mid-delay is ignored.
    retrigger = 1'b1; tick(); retrigger = 1'b0;
    expect0("retrig_done", 1'b0, 1'b0, 2'd1, 8'd0);
    run(3);
    expect0("delay_at_3", 1'b0, 1'b0, 2'd1, 8'd3);
    retrigger = 1'b1; tick(); retrigger = 1'b0;
    expect0("retrig_ignored", 1'b0, 1'b0, 2'd1, 8'd4);
    run(5);
    expect0("delay_at_9", 1'b0, 1'b0, 2'd1, 8'd9);
    tick(); expect0("retrig_start1", 1'b0, 1'b1, 2'd2, 8'd9);
    tick(); expect0("retrig_start2", 1'b0, 1'b1, 2'd2, 8'd9);
    tick(); expect0("retrig_done2", 1'b0, 1'b0, 2'd3, 8'd9);

    // eos glitch mid-delay restarts the whole sequence.
    retrigger = 1'b1; tick(); retrigger = 1'b0;
    run(5);
    expect0("delay_at_5", 1'b0, 1'b0, 2'd1, 8'd5);
    eos = 1'b0; tick(); eos = 1'b1;
    expect0("eos_low", 1'b1, 1'b0, 2'd0, 8'd0);
    run(RH - 1);
    expect0("eos_hold", 1'b1, 1'b0, 2'd0, 8'd0);
    tick(); expect0("eos_release", 1'b0, 1'b0, 2'd1, 8'd0);
    run(SD - 1);
    expect0("no_early_start", 1'b0, 1'b0, 2'd1, 8'd9);
    tick(); expect0("eos_start", 1'b0, 1'b1, 2'd2, 8'd9);
    run(2);
    expect0("eos_done", 1'b0, 1'b0, 2'd3, 8'd9);

    // Masked request is ignored; unmasking it asserts reset on the next edge.
    retrigger = 1'b1; tick(); retrigger = 1'b0;
    rst_req = 2'b10; rst_mask = 2'b10;
    run(2);
    expect0("masked_req", 1'b0, 1'b0, 2'd1, 8'd2);
    rst_mask = 2'b00; tick();
    expect0("unmasked", 1'b1, 1'b0, 2'd0, 8'd0);
    run(2);
    expect0("req_held", 1'b1, 1'b0, 2'd0, 8'd0);
    rst_req = 2'b00;
    run(RH - 1);
    expect0("req_hold", 1'b1, 1'b0, 2'd0, 8'd0);
    tick(); expect0("req_release", 1'b0, 1'b0, 2'd1, 8'd0);

    // Request arriving in the first start cycle kills the pulse.
    run(SD);
    expect0("first_start", 1'b0, 1'b1, 2'd2, 8'd9);
    rst_req = 2'b01; tick(); rst_req = 2'b00;
    expect0("cause_in_pulse", 1'b1, 1'b0, 2'd0, 8'd0);
    run(RH);
    expect0("pulse_kill_release", 1'b0, 1'b0, 2'd1, 8'd0);

    // Retrigger together with rst: reset wins.
    run(SD + PW);
    expect0("done_again", 1'b0, 1'b0, 2'd3, 8'd9);
    retrigger = 1'b1; rst = 1'b1; tick(); retrigger = 1'b0; rst = 1'b0;
    expect0("retrig_vs_rst", 1'b1, 1'b0, 2'd0, 8'd0);
    run(RH - 1);
    expect0("retrig_vs_rst_hold", 1'b1, 1'b0, 2'd0, 8'd0);
    tick(); expect0("periodic_release", 1'b0, 1'b0, 2'd1, 8'd0);

    // Periodic instance: pulses of PW cycles every SD+PW cycles, never DONE.
    for (int i = 1; i <= 40; i++) begin
      logic exp_start;
      tick();
      exp_start = (i >= SD) && (((i - SD) % (SD + PW)) < PW);
      checks++;
      if (st1 !== exp_start || s1 == 2'd3) begin
        errors++;
        $display("FAIL periodic_c%0d: got start=%b state=%0d, want start=%b state!=3",
                 i, st1, s1, exp_start);
      end
    end

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom % 200 == 0);
      eos       = !($urandom % 150 == 0);
      rst_req   = ($urandom % 60 == 0) ? 2'($urandom) : 2'b00;
      rst_mask  = 2'($urandom);
      retrigger = ($urandom % 6 == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
